ycbcr_share_arb: RTL
====================

YCBCR_SHARE_ARB -- requirements
Module: ycbcr_share_arb

Interface
REQ-001 SHALL have parameter CONV_LAT, default 3: fixed latency in cycles of the shared RGB888-to-YCbCr converter.
REQ-002 SHALL have parameter BURST_MAX, default 16: maximum number of pixels accepted per grant.
REQ-003 SHALL have port clk, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have ports req0_valid/req1_valid, input, 1 bit each: the requester presents a pixel.
REQ-006 SHALL have ports req0_data/req1_data, input, 24 bits each: RGB888 pixel, {R,G,B}.
REQ-007 SHALL have ports req0_ready/req1_ready, output, 1 bit each: the arbiter accepts the pixel this cycle.
REQ-008 SHALL have port conv_din, output, 24 bits: pixel driven to the converter input.
REQ-009 SHALL have port conv_dout, input, 24 bits: converter result.
REQ-010 SHALL have ports rsp0_valid/rsp1_valid, output, 1 bit each: the result belongs to this requester.
REQ-011 SHALL have ports rsp0_data/rsp1_data, output, 24 bits each: converted pixel.
REQ-012 SHALL have ports stat0_cnt/stat1_cnt, output, 16 bits each: accepted-pixel counters (see Configuration).

Function
REQ-013 SHALL implement the FSM states IDLE, GNT0 and GNT1.
REQ-014 In IDLE, req0_ready and req1_ready SHALL both be 0.
REQ-015 In IDLE with exactly one reqN_valid high, the FSM SHALL move to GNTN on the next clock.
REQ-016 In IDLE with both valids high, the FSM SHALL grant the requester selected by the round-robin pointer rr, a 1-bit register holding the preferred requester.
REQ-017 In GNTN, reqN_ready SHALL be 1 and the other ready SHALL be 0; a transfer SHALL occur when reqN_valid and reqN_ready are both high.
REQ-018 Each transfer in GNTN SHALL increment burst counter bc.
REQ-019 GNTN SHALL end when reqN_valid is low, or when a transfer makes bc equal to BURST_MAX.
REQ-020 On leaving GNTN, rr SHALL be set to the other requester and bc SHALL be cleared.
REQ-021 On leaving GNTN, the next state SHALL be GNT(other) if the other valid is high; otherwise GNTN again if reqN_valid is high and the burst expired; otherwise IDLE.
REQ-022 SHALL accept at most one pixel per cycle, and never both requesters in the same cycle.
REQ-023 A transfer in cycle T SHALL register the pixel into conv_din, visible in cycle T+1.
REQ-024 conv_din SHALL hold its value when no transfer occurs.
REQ-025 SHALL track in-flight pixels with a {valid, tag} shift register aligned so that tag/valid match conv_dout in cycle T+1+CONV_LAT.
REQ-026 rsp outputs SHALL be registered; for a requester-N transfer in cycle T, rspN_valid=1 and rspN_data=conv_dout SHALL appear in cycle T+2+CONV_LAT (default T+5) for exactly one cycle.
REQ-027 Whenever rspN_valid is 0, rspN_data SHALL be 0.
REQ-028 Responses SHALL leave in acceptance order with no backpressure, because the converter never stalls.
REQ-029 A requester dropping valid mid-burst SHALL create no pipeline bubble for the other requester beyond the single cycle of the state change.

Reset
REQ-030 On rst assertion, the state SHALL become IDLE, rr=0, bc=0, conv_din=0, all delay-line valids=0, all ready and rsp outputs=0, and stat counters=0.
REQ-031 Pixels in flight at reset SHALL be discarded and never produce an rsp pulse.
REQ-032 After rst deasserts, the first simultaneous request SHALL be granted to requester 0.

Configuration
REQ-033 With macro YCBCR_ARB_STATS_EN defined, statN_cnt SHALL increment on each requester-N transfer and wrap from 0xFFFF to 0x0000.
REQ-034 Without YCBCR_ARB_STATS_EN, statN_cnt SHALL be tied to 0 and no counter logic SHALL be synthesized; ports SHALL be unchanged.

Verification
REQ-035 Scenario: only req0 valid, 4 pixels 0xFF0000..., starting in IDLE -> req0_ready rises 1 cycle later; 4 rsp0 pulses 5 cycles after each accept; rsp1_valid stays 0.
REQ-036 Scenario: both valid from reset, continuous -> 16 req0 accepts, then 16 req1 accepts, alternating; no cycle carries both readys.
REQ-037 Scenario: req0 only, 40 continuous pixels -> bursts of 16, 16 and 8 with no IDLE gap at the burst boundaries.
REQ-038 Scenario: converter model of latency 3, interleaved tags -> each rspN_data matches the converter result of that requester's pixel; ordering is preserved.
REQ-039 Scenario: rst asserted 2 cycles after 3 accepts -> no rsp pulse afterwards; all outputs are 0 while rst is high.
REQ-040 Scenario: with YCBCR_ARB_STATS_EN, 65537 req1 pixels -> stat1_cnt=1; built without the macro -> stat1_cnt=0 throughout.

Source files
------------

// File: rtl/ycbcr_share_arb.sv
// rtl/ycbcr_share_arb.sv - two-requester arbiter sharing one fixed-latency RGB888-to-YCbCr converter
//
// Purpose:
//   Two pixel requesters share one pipelined converter that never stalls.
//   A three-state FSM (IDLE, GNT0, GNT1) grants one requester at a time.
//   A grant lasts for up to BURST_MAX accepted pixels. When both requesters
//   are waiting, a one-bit round-robin pointer decides who goes first.
//   Each accepted pixel is registered onto conv_din. A {valid, tag} delay
//   line follows the pixel through the converter, so each result can be
//   routed back to the requester that sent it.
//
// Parameters:
//   CONV_LAT   converter latency in cycles (conv_din -> conv_dout)
//   BURST_MAX  maximum pixels accepted per grant
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   reqN_valid/data/ready     pixel request channels, RGB888 {R,G,B}
//   conv_din / conv_dout      converter input (registered) / converter result
//   rspN_valid/data           registered per-requester result (data is 0 when not valid)
//   statN_cnt                 accepted-pixel counters
//
// Configuration:
//   YCBCR_ARB_STATS_EN        when defined, statN_cnt count accepted pixels
//                             and wrap at 16 bits. Otherwise they are tied to 0.

module ycbcr_share_arb #(
    parameter int CONV_LAT  = 3,
    parameter int BURST_MAX = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [23:0] req0_data,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [23:0] req1_data,
    output logic        req1_ready,
    output logic [23:0] conv_din,
    input  logic [23:0] conv_dout,
    output logic        rsp0_valid,
    output logic [23:0] rsp0_data,
    output logic        rsp1_valid,
    output logic [23:0] rsp1_data,
    output logic [15:0] stat0_cnt,
    output logic [15:0] stat1_cnt
);

    localparam int                BC_W   = $clog2(BURST_MAX + 1);
    localparam logic [BC_W-1:0]   BC_MAX = BC_W'(BURST_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              rr_q, rr_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [BC_W-1:0]   bc_inc;

    logic [23:0]       conv_din_q, conv_din_d;
    logic [CONV_LAT:0] pv_q, pv_d;
    logic [CONV_LAT:0] pt_q, pt_d;

    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [23:0]       rsp0_data_q, rsp0_data_d;
    logic [23:0]       rsp1_data_q, rsp1_data_d;

    // Signals shared by the FSM and the datapath
    logic              xfer;
    logic              xfer_tag;
    logic [23:0]       xfer_data;
    logic              cur;
    logic              cur_valid;
    logic              oth_valid;
    logic              expired;

    assign bc_inc = bc_q + 1'b1;

    // ------------------------------------------------------------------
    // Arbitration FSM: next state, grant bookkeeping and ready outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        bc_d       = bc_q;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        xfer       = 1'b0;
        xfer_tag   = 1'b0;
        xfer_data  = 24'h0;
        cur        = 1'b0;
        cur_valid  = 1'b0;
        oth_valid  = 1'b0;
        expired    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_valid && req1_valid) begin
                    state_d = rr_q ? GNT1 : GNT0;
                end else if (req0_valid) begin
                    state_d = GNT0;
                end else if (req1_valid) begin
                    state_d = GNT1;
                end
            end

            GNT0, GNT1: begin
                cur        = (state_q == GNT1);
                cur_valid  = cur ? req1_valid : req0_valid;
                oth_valid  = cur ? req0_valid : req1_valid;
                req0_ready = !cur;
                req1_ready = cur;
                xfer       = cur_valid;
                xfer_tag   = cur;
                xfer_data  = cur ? req1_data : req0_data;
                expired    = cur_valid && (bc_inc == BC_MAX);

                if (!cur_valid || expired) begin
                    rr_d = !cur;
                    bc_d = '0;
                    if (oth_valid) begin
                        state_d = cur ? GNT0 : GNT1;
                    end else if (expired) begin
                        // Only this requester is still waiting. It is
                        // re-granted straight away, so no IDLE cycle
                        // appears at the burst boundary.
                        state_d = state_q;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    bc_d = bc_inc;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: converter input register, tag delay line, response routing
    // ------------------------------------------------------------------
    always_comb begin
        conv_din_d = xfer ? xfer_data : conv_din_q;

        // Stage 0 is loaded together with conv_din. Stage CONV_LAT
        // therefore lines up with conv_dout for the same pixel.
        pv_d    = '0;
        pt_d    = '0;
        pv_d[0] = xfer;
        pt_d[0] = xfer_tag;
        for (int i = 1; i <= CONV_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pt_d[i] = pt_q[i-1];
        end

        rsp0_valid_d = pv_q[CONV_LAT] && !pt_q[CONV_LAT];
        rsp1_valid_d = pv_q[CONV_LAT] &&  pt_q[CONV_LAT];
        rsp0_data_d  = rsp0_valid_d ? conv_dout : 24'h0;
        rsp1_data_d  = rsp1_valid_d ? conv_dout : 24'h0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            rr_q         <= 1'b0;
            bc_q         <= '0;
            conv_din_q   <= 24'h0;
            pv_q         <= '0;
            pt_q         <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= 24'h0;
            rsp1_data_q  <= 24'h0;
        end else begin
            state_q      <= state_d;
            rr_q         <= rr_d;
            bc_q         <= bc_d;
            conv_din_q   <= conv_din_d;
            pv_q         <= pv_d;
            pt_q         <= pt_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp0_data_q  <= rsp0_data_d;
            rsp1_data_q  <= rsp1_data_d;
        end
    end

    assign conv_din   = conv_din_q;
    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_data  = rsp0_data_q;
    assign rsp1_data  = rsp1_data_q;

    // ------------------------------------------------------------------
    // Optional accepted-pixel statistics
    // ------------------------------------------------------------------
`ifdef YCBCR_ARB_STATS_EN
    logic [15:0] stat0_q, stat0_d;
    logic [15:0] stat1_q, stat1_d;

    always_comb begin
        stat0_d = stat0_q + {15'h0, (xfer && !xfer_tag)};
        stat1_d = stat1_q + {15'h0, (xfer &&  xfer_tag)};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat0_q <= 16'h0;
            stat1_q <= 16'h0;
        end else begin
            stat0_q <= stat0_d;
            stat1_q <= stat1_d;
        end
    end

    assign stat0_cnt = stat0_q;
    assign stat1_cnt = stat1_q;
`else
    assign stat0_cnt = 16'h0;
    assign stat1_cnt = 16'h0;
`endif

endmodule
